digit_serial_adder_subtractor: RTL and testbench

//   Parametrised, multi-cycle signed/unsigned adder-subtractor. Computes A+B (M=0) or A-B (M=1) in two's complement.

---
 rtl/digit_serial_adder_subtractor.sv | 106 ++++++++++
 tb/tb_digit_serial_adder_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-wide slice, LSB digit first.
// Optional `SATURATE_EN clamps S to the signed limit on overflow.
module digit_serial_adder_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    // start is sampled only while busy is low; an accepted start raises busy for NDIG cycles.
    // After the last cycle, done pulses for one cycle and S/C/V/Z are updated.
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;

    stateT            state;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opBx;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] aDig;
    logic [DIGIT-1:0] bDig;
    logic [DIGIT:0]   digSum;
    logic             carryIntoMsb;
    logic             overflow;
    logic [WIDTH-1:0] rawSum;
    logic [WIDTH-1:0] finalSum;

    always_comb begin
        aDig   = opA[int'(cnt) * DIGIT +: DIGIT];
        bDig   = opBx[int'(cnt) * DIGIT +: DIGIT];
        digSum = {1'b0, aDig} + {1'b0, bDig} + {{DIGIT{1'b0}}, carry};
        // Carry into a sum bit is a ^ b ^ sum; only meaningful on the last digit's top bit.
        carryIntoMsb = aDig[DIGIT-1] ^ bDig[DIGIT-1] ^ digSum[DIGIT-1];
        overflow     = carryIntoMsb ^ digSum[DIGIT];
        rawSum = acc;
        rawSum[int'(cnt) * DIGIT +: DIGIT] = digSum[DIGIT-1:0];
        finalSum = rawSum;
`ifdef SATURATE_EN
        if (overflow) begin
            finalSum = opA[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opA   <= '0;
            opBx  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            S     <= '0;
            C     <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opA   <= A;
                        opBx  <= B ^ {WIDTH{M}};
                        carry <= M;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= rawSum;
                    carry <= digSum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_DIG) begin
                        state <= IDLE;
                        S     <= finalSum;
                        C     <= digSum[DIGIT];
                        V     <= overflow;
                        Z     <= (finalSum == '0);
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_digit_serial_adder_subtractor.sv
// Bench for digit_serial_adder_subtractor: DIGIT=4 and DIGIT=16 instances checked
// against an integer-arithmetic reference model through an expected-result queue.
module tb_digit_serial_adder_subtractor;
    localparam int WIDTH = 16;
    localparam int NDIG4 = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start4 = 1'b0;
    logic             start16 = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             M = 1'b0;

    logic             busy4, done4, C4, V4, Z4;
    logic [WIDTH-1:0] S4;
    logic             busy16, done16, C16, V16, Z16;
    logic [WIDTH-1:0] S16;

    logic             useWide = 1'b0;
    logic             obsBusy, obsDone, obsC, obsV, obsZ;
    logic [WIDTH-1:0] obsS;

    int nChecks = 0;
    int nFails = 0;
    logic [WIDTH+2:0] expQ[$];
    logic [WIDTH-1:0] lastS = '0;

    digit_serial_adder_subtractor #(.WIDTH(WIDTH), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(A), .B(B), .M(M),
        .busy(busy4), .done(done4), .S(S4), .C(C4), .V(V4), .Z(Z4)
    );

    digit_serial_adder_subtractor #(.WIDTH(WIDTH), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(A), .B(B), .M(M),
        .busy(busy16), .done(done16), .S(S16), .C(C16), .V(V16), .Z(Z16)
    );

    assign obsBusy = useWide ? busy16 : busy4;
    assign obsDone = useWide ? done16 : done4;
    assign obsS    = useWide ? S16 : S4;
    assign obsC    = useWide ? C16 : C4;
    assign obsV    = useWide ? V16 : V4;
    assign obsZ    = useWide ? Z16 : Z4;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, packed as {S, C, V, Z}.
    function automatic logic [WIDTH+2:0] refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic m);
        longint sa, sb, ua, ub, res;
        logic [WIDTH-1:0] s;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (m) begin
            res = sa - sb;
            c   = (ua >= ub);
        end else begin
            res = sa + sb;
            c   = ((ua + ub) >= (longint'(1) << WIDTH));
        end
        v = (res > ((longint'(1) << (WIDTH - 1)) - 1)) || (res < -(longint'(1) << (WIDTH - 1)));
        s = res[WIDTH-1:0];
`ifdef SATURATE_EN
        if (v) s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return {s, c, v, (s == '0)};
    endfunction

    // Driver: call at #1 after an edge; returns #1 after the accepting edge.
    task automatic startOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
        A = a;
        B = b;
        M = m;
        if (useWide) start16 = 1'b1;
        else start4 = 1'b1;
        expQ.push_back(refModel(a, b, m));
        @(posedge clk); #1;
        start4 = 1'b0;
        start16 = 1'b0;
        checkVal("busy_after_start", obsBusy, 1);
    endtask

    // Bounded wait for done; checks latency, held S while running, then the result.
    task automatic waitDone(input int elapsed);
        int cyc;
        int expLat;
        logic [WIDTH+2:0] e;
        cyc = elapsed;
        expLat = useWide ? 1 : NDIG4;
        while (obsDone !== 1'b1 && cyc < 20) begin
            checkVal("hold_S", obsS, lastS);
            @(posedge clk); #1;
            cyc++;
        end
        checkVal("latency", cyc, expLat);
        checkVal("busy_at_done", obsBusy, 0);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal("S", obsS, e[WIDTH+2:3]);
            checkVal("C", obsC, e[2]);
            checkVal("V", obsV, e[1]);
            checkVal("Z", obsZ, e[0]);
            lastS = e[WIDTH+2:3];
        end
    endtask

    task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m);
        startOp(a, b, m);
        waitDone(0);
        @(posedge clk); #1;
        checkVal("done_pulse", obsDone, 0);
    endtask

    initial begin
        // Reset values on both instances
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_busy", busy4, 0);
        checkVal("rst_done", done4, 0);
        checkVal("rst_S", S4, 0);
        checkVal("rst_C", C4, 0);
        checkVal("rst_V", V4, 0);
        checkVal("rst_Z", Z4, 0);
        checkVal("rst_busy16", busy16, 0);
        checkVal("rst_S16", S16, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed boundary vectors
        runOp(16'h7FFF, 16'h0001, 1'b0);
        runOp(16'h0005, 16'h0007, 1'b1);
        runOp(16'hFFFF, 16'h0001, 1'b0);
        runOp(16'h8000, 16'h0001, 1'b1);
        runOp(16'h0000, 16'h0000, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted
        startOp(16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        start4 = 1'b1;
        A = 16'hFFFF;
        B = 16'h4321;
        @(posedge clk); #1;
        start4 = 1'b0;
        waitDone(2);
        checkVal("hs_S1", obsS, 16'h2345);
        startOp(16'h0001, 16'h0001, 1'b0);
        waitDone(0);
        checkVal("hs_S2", obsS, 16'h0002);
        @(posedge clk); #1;
        checkVal("done_pulse", obsDone, 0);

        // Reset during an operation
        startOp(16'h4444, 16'h1111, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkVal("midrst_busy", busy4, 0);
        checkVal("midrst_done", done4, 0);
        checkVal("midrst_S", S4, 0);
        checkVal("midrst_C", C4, 0);
        checkVal("midrst_Z", Z4, 0);
        expQ.delete();
        lastS = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkVal("midrst_no_done", done4, 0);
        end
        runOp(16'h4444, 16'h1111, 1'b0);

        // Random operations, mixing back-to-back starts in the done cycle
        for (int i = 0; i < 40; i++) begin
            startOp(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            waitDone(0);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
                checkVal("done_pulse", obsDone, 0);
            end
        end
        @(posedge clk); #1;

        // Single-digit instance: done one cycle after start
        useWide = 1'b1;
        lastS = '0;
        runOp(16'h7FFF, 16'h0001, 1'b0);
        runOp(16'hFFFF, 16'h0001, 1'b0);
        runOp(16'h8000, 16'h0001, 1'b1);
        for (int i = 0; i < 15; i++) begin
            startOp(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            waitDone(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
